fifo_sample_drain: RTL and testbench
====================================

# fifo_sample_drain

Rate-paced reader for the sync FIFO read port. It pops one sample every `rate_div+1` clocks and presents it to the DAC datapath as a registered sample with a one-cycle valid strobe. FIFO underruns are absorbed by holding the last sample, then muting after a configurable run of misses. It sits between the sample FIFO and the interpolator/modulator.

## Interface
- `DWIDTH`, 32: sample width; must match the FIFO data width.
- `DIV_WIDTH`, 16: width of the rate divider.
- `MUTE_AFTER`, 4: consecutive underrun ticks before muting; legal range 1..255.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; level sensitive.
- `rate_div` in DIV_WIDTH: tick period minus 1, sampled at each counter reload.
- `fifo_rdata` in DWIDTH: FIFO read data; combinational from the current read pointer.
- `fifo_empty` in 1: FIFO empty flag; registered in the FIFO.
- `fifo_read_en` out 1: pop request to the FIFO.
- `sample_out` out DWIDTH: current sample to the DAC path; registered.
- `sample_vld` out 1: one-cycle strobe per tick; registered.
- `underrun` out 1: sticky underrun flag.
- `underrun_clr` in 1: synchronous clear of `underrun` and of the underrun counter.
- `muted` out 1: high while in STARVE.

## Operation
- **States:** IDLE, PRIME, RUN, STARVE.
- **IDLE:**
  - `fifo_read_en`=0; tick counter is held.
  - `sample_out` and `underrun` keep their values.
  - `enable`=1 → PRIME.
- **PRIME:**
  - No ticks and no `sample_vld`.
  - `!fifo_empty` → RUN; the tick counter loads `rate_div`.
- **RUN:**
  - The tick counter decrements each cycle. `tick` = (counter==0); on a tick the counter reloads `rate_div`.
  - Tick with `!fifo_empty`:
    - `fifo_read_en`=1 in that cycle.
    - `sample_out` ← `fifo_rdata` at the edge.
    - Miss counter ← 0.
  - Tick with `fifo_empty`:
    - `sample_out` holds; `underrun` ← 1; miss counter +1.
    - When the miss counter reaches MUTE_AFTER → STARVE, and `sample_out` ← 0 at that edge.
  - Every RUN tick produces a `sample_vld` pulse on the next cycle, hit or miss. The DAC must never skip a slot.
- **STARVE:**
  - Ticks continue; each tick produces `sample_vld` with `sample_out`=0.
  - `!fifo_empty` observed on any cycle → PRIME, which reloads cadence cleanly; the miss counter clears.
- **`enable`=0 in any state:**
  - → IDLE at the next edge.
  - `fifo_read_en` is gated by `enable` combinationally, so no pop occurs in the deassert cycle.
- **`fifo_read_en` rule:** it is combinational: (state==RUN) & `tick` & `!fifo_empty` & `enable`. It is never asserted while `fifo_empty`=1.
- **Miss counter:** 8 bits, saturating.
- **`underrun_clr` vs. a miss tick in the same cycle:** the set wins.

## Timing
- **Reset values:**
  - state IDLE
  - `sample_out`=0, `sample_vld`=0, `underrun`=0, `muted`=0
  - tick counter=0, miss counter=0
  - `fifo_read_en`=0
- **Pop-to-output latency:** `sample_out` changes at the edge ending the pop cycle; `sample_vld` is high during the following cycle.
- **Tick period:** `rate_div`+1 clocks. `rate_div`=0 gives a tick every cycle, i.e. back-to-back pops.
- **First tick:** after PRIME→RUN, the first tick lands `rate_div`+1 cycles after entry into RUN.
- **Changing `rate_div`:** a change takes effect at the next reload only.
- **`muted`:** registered; rises with the STARVE entry edge and falls on STARVE→PRIME.
- **Reset asserted mid-operation:** all state clears immediately. A pop cycle truncated by reset counts as no pop.

## Configuration
- **`FIFO_SAMPLE_DRAIN_UFLOW_CNT_EN`**
  - Defined: adds output `uflow_cnt` [15:0], which counts miss ticks.
    - Saturates at 16'hFFFF; cleared by `underrun_clr`.
    - If the clear and a miss occur in the same cycle, the count becomes 1.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- **Shared package `dac_pkg`:**
  - state enum `drain_state_t` (IDLE, PRIME, RUN, STARVE)
  - constant `MISS_CNT_W`=8
  - constant `UFLOW_CNT_W`=16
- **Sub-module `rate_tick_gen`:** loadable down-counter that emits `tick` and reloads `rate_div`. Its `load` input is driven on entry to RUN.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs 0, state IDLE. Release with `enable`=0 → no `fifo_read_en` for 100 cycles.
- **Steady run:**
  - Stimulus: `rate_div`=3; FIFO preloaded with 0x11,0x22,0x33; `enable`=1.
  - Response: pops exactly every 4 cycles. `sample_out`=0x11,0x22,0x33 in order, each with one `sample_vld` pulse the cycle after its pop.
- **Underrun hold and mute:**
  - Stimulus: MUTE_AFTER=2, `rate_div`=1, one word 0xAB, then the FIFO stays empty.
  - Response: vld with 0xAB, then 0xAB again with `underrun`=1. The next miss tick gives 0 with `muted`=1; later ticks give 0.
- **Recovery:** from STARVE, write 0x5A → PRIME, then RUN. First tick after `rate_div`+1 cycles outputs 0x5A; `muted`=0.
- **Disable mid-run:** deassert `enable` in a tick cycle with the FIFO non-empty → `fifo_read_en`=0 that cycle, FIFO read pointer unchanged, state IDLE, `sample_out` held.
- **Back-to-back:** `rate_div`=0 with 16 words queued → 16 consecutive pops and 16 consecutive `sample_vld` cycles; `fifo_read_en` is low in the cycle `fifo_empty` rises.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and widths for the DAC sample path.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    STARVE
  } drain_state_t;

  localparam int MISS_CNT_W  = 8;
  localparam int UFLOW_CNT_W = 16;

endpackage

// File: rtl/rate_tick_gen.sv
// Loadable down-counter that paces sample pops: tick when the count hits zero,
// then reload the current rate_div so period changes land only at a reload.
module rate_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] rate_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = run && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= rate_div;
    end else if (run) begin
      count <= tick ? rate_div : count - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sample_drain.sv
// Rate-paced FIFO reader feeding the DAC path; holds then mutes on underrun.
// Optional uflow_cnt output is built when FIFO_SAMPLE_DRAIN_UFLOW_CNT_EN is defined.
module fifo_sample_drain
  import dac_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int DIV_WIDTH  = 16,
  parameter int MUTE_AFTER = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DIV_WIDTH-1:0]   rate_div,
  input  logic [DWIDTH-1:0]      fifo_rdata,
  input  logic                   fifo_empty,
  output logic                   fifo_read_en,
  output logic [DWIDTH-1:0]      sample_out,
  output logic                   sample_vld,
  output logic                   underrun,
  input  logic                   underrun_clr,
  output logic                   muted
`ifdef FIFO_SAMPLE_DRAIN_UFLOW_CNT_EN
  ,output logic [UFLOW_CNT_W-1:0] uflow_cnt
`endif
);

  localparam logic [MISS_CNT_W-1:0] MUTE_LVL = MISS_CNT_W'(MUTE_AFTER);

  drain_state_t          state;
  logic [MISS_CNT_W-1:0] miss_cnt;
  logic [MISS_CNT_W-1:0] miss_base;
  logic [MISS_CNT_W-1:0] miss_inc;
  logic                  tick;
  logic                  load;
  logic                  run_cnt;
  logic                  hit;
  logic                  miss;
  logic                  mute_now;

  assign load    = enable && (state == PRIME) && !fifo_empty;
  assign run_cnt = enable && ((state == RUN) || (state == STARVE));

  rate_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .run      (run_cnt),
    .rate_div (rate_div),
    .tick     (tick)
  );

  assign hit          = (state == RUN) && tick && !fifo_empty && enable;
  assign fifo_read_en = hit;
  assign miss         = tick && fifo_empty;

  // A clear in the same cycle as a miss restarts the run at one.
  assign miss_base = underrun_clr ? '0 : miss_cnt;
  assign miss_inc  = (&miss_base) ? miss_base : miss_base + 1'b1;
  assign mute_now  = (state == RUN) && miss && (miss_inc >= MUTE_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_out <= '0;
      sample_vld <= 1'b0;
      underrun   <= 1'b0;
      muted      <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      sample_vld <= tick;
      if (underrun_clr) begin
        underrun <= 1'b0;
        miss_cnt <= '0;
      end
      if (miss) begin
        underrun <= 1'b1;
        miss_cnt <= miss_inc;
      end
      if (!enable) begin
        state <= IDLE;
        muted <= 1'b0;
      end else begin
        case (state)
          IDLE:  state <= PRIME;
          PRIME: if (!fifo_empty) state <= RUN;
          RUN: begin
            if (hit) begin
              sample_out <= fifo_rdata;
              miss_cnt   <= '0;
            end else if (mute_now) begin
              state      <= STARVE;
              muted      <= 1'b1;
              sample_out <= '0;
            end
          end
          STARVE: begin
            // Any data arriving restarts cadence from PRIME rather than mid-period.
            if (!fifo_empty) begin
              state    <= PRIME;
              muted    <= 1'b0;
              miss_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FIFO_SAMPLE_DRAIN_UFLOW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uflow_cnt <= '0;
    end else if (miss) begin
      uflow_cnt <= underrun_clr ? UFLOW_CNT_W'(1)
                 : ((&uflow_cnt) ? uflow_cnt : uflow_cnt + 1'b1);
    end else if (underrun_clr) begin
      uflow_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sample_drain.sv
// Self-checking bench for fifo_sample_drain: cycle model plus directed scenarios.
module tb_fifo_sample_drain;

  localparam int MUTE = 2;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_STARVE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] rate_div;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_read_en;
  logic [31:0] sample_out;
  logic        sample_vld;
  logic        underrun;
  logic        underrun_clr;
  logic        muted;
`ifdef FIFO_SAMPLE_DRAIN_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
`endif

  fifo_sample_drain #(.DWIDTH(32), .DIV_WIDTH(16), .MUTE_AFTER(MUTE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .rate_div     (rate_div),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .fifo_read_en (fifo_read_en),
    .sample_out   (sample_out),
    .sample_vld   (sample_vld),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .muted        (muted)
`ifdef FIFO_SAMPLE_DRAIN_UFLOW_CNT_EN
    ,.uflow_cnt   (uflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bench-side FIFO: registered pointers, combinational read data.
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_flush = 1'b0;
  logic [5:0]  rd_idx;

  assign rd_idx     = rd_ptr[5:0];
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_idx];

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_read_en) rd_ptr <= rd_ptr + 1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic cmp_on = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tick times as absolute cycle numbers instead of a counter.
  int          m_mode, m_miss, m_due;
  logic [31:0] m_samp;
  logic        m_vld, m_und, m_muted;
  logic        t_now, p_now, x_now;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_miss = 0; m_due = 0;
      m_samp = 0; m_vld = 0; m_und = 0; m_muted = 0;
    end else begin
      t_now = enable && (m_mode == M_RUN || m_mode == M_STARVE) && (cyc == m_due);
      p_now = t_now && (m_mode == M_RUN) && !fifo_empty;
      x_now = t_now && fifo_empty;
      m_vld = t_now;
      if (t_now) m_due = cyc + int'(rate_div) + 1;
      if (underrun_clr) begin m_und = 0; m_miss = 0; end
      if (x_now) begin m_und = 1; if (m_miss < 255) m_miss++; end
      if (!enable) m_mode = M_IDLE;
      else case (m_mode)
        M_IDLE:  m_mode = M_PRIME;
        M_PRIME: if (!fifo_empty) begin m_mode = M_RUN; m_due = cyc + int'(rate_div) + 1; end
        M_RUN: begin
          if (p_now) begin m_samp = fifo_rdata; m_miss = 0; end
          else if (x_now && m_miss >= MUTE) begin m_mode = M_STARVE; m_samp = 0; end
        end
        default: if (!fifo_empty) begin m_mode = M_PRIME; m_miss = 0; end
      endcase
      m_muted = (m_mode == M_STARVE);
      cyc++;
    end
  end

  // Compare every cycle, and log pops and strobes for the directed checks.
  int          pop_cyc[$];
  int          vld_cyc[$];
  logic [31:0] vld_s[$];
  logic        vld_u[$];
  logic        vld_m[$];

  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      check_output("sample_out", sample_out, m_samp);
      check_output("sample_vld", 32'(sample_vld), 32'(m_vld));
      check_output("underrun", 32'(underrun), 32'(m_und));
      check_output("muted", 32'(muted), 32'(m_muted));
      check_output("fifo_read_en", 32'(fifo_read_en),
                   32'(m_mode == M_RUN && cyc == m_due && enable && !fifo_empty));
      check_output("rd_when_empty", 32'(fifo_read_en & fifo_empty), 32'd0);
      if (fifo_read_en) pop_cyc.push_back(cyc);
      if (sample_vld) begin
        vld_cyc.push_back(cyc);
        vld_s.push_back(sample_out);
        vld_u.push_back(underrun);
        vld_m.push_back(muted);
      end
    end
  end

  task automatic apply_stimulus(input logic en, input logic [15:0] rd, input int n);
    enable   = en;
    rate_div = rd;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [31:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic clear_logs();
    pop_cyc.delete(); vld_cyc.delete(); vld_s.delete(); vld_u.delete(); vld_m.delete();
  endtask

  int rp;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_n = 1'b0; enable = 1'b0; rate_div = '0; underrun_clr = 1'b0;
    apply_stimulus(1'b0, 16'd0, 3);
    check_output("rst_sample_out", sample_out, 32'd0);
    check_output("rst_sample_vld", 32'(sample_vld), 32'd0);
    check_output("rst_underrun", 32'(underrun), 32'd0);
    check_output("rst_muted", 32'(muted), 32'd0);
    check_output("rst_read_en", 32'(fifo_read_en), 32'd0);
    rst_n = 1'b1; cmp_on = 1'b1;

    $display("[TB] idle after reset");
    apply_stimulus(1'b0, 16'd0, 100);
    check_output("idle_pops", pop_cyc.size(), 32'd0);

    $display("[TB] steady run, rate_div=3");
    push(32'h11); push(32'h22); push(32'h33);
    apply_stimulus(1'b1, 16'd3, 15);
    apply_stimulus(1'b0, 16'd3, 2);
    check_output("steady_pops", pop_cyc.size(), 32'd3);
    if (pop_cyc.size() == 3 && vld_s.size() >= 3) begin
      check_output("steady_gap0", pop_cyc[1] - pop_cyc[0], 32'd4);
      check_output("steady_gap1", pop_cyc[2] - pop_cyc[1], 32'd4);
      check_output("steady_vld_lat", vld_cyc[0] - pop_cyc[0], 32'd1);
      check_output("steady_s0", vld_s[0], 32'h11);
      check_output("steady_s1", vld_s[1], 32'h22);
      check_output("steady_s2", vld_s[2], 32'h33);
    end else check_output("steady_log_size", vld_s.size(), 32'd3);

    $display("[TB] underrun hold and mute, rate_div=1");
    clear_logs();
    push(32'hAB);
    apply_stimulus(1'b1, 16'd1, 14);
    if (vld_s.size() >= 4) begin
      check_output("ur_s0", vld_s[0], 32'hAB);
      check_output("ur_u0", 32'(vld_u[0]), 32'd0);
      check_output("ur_s1", vld_s[1], 32'hAB);
      check_output("ur_u1", 32'(vld_u[1]), 32'd1);
      check_output("ur_s2", vld_s[2], 32'h0);
      check_output("ur_m2", 32'(vld_m[2]), 32'd1);
      check_output("ur_s3", vld_s[3], 32'h0);
    end else check_output("ur_log_size", vld_s.size(), 32'd4);

    $display("[TB] recovery from starve");
    clear_logs();
    push(32'h5A);
    apply_stimulus(1'b1, 16'd1, 4);
    apply_stimulus(1'b0, 16'd1, 1);
    if (vld_s.size() > 0) begin
      check_output("rec_sample", vld_s[vld_s.size()-1], 32'h5A);
      check_output("rec_muted", 32'(vld_m[vld_m.size()-1]), 32'd0);
    end else check_output("rec_log_size", vld_s.size(), 32'd1);
    check_output("rec_underrun_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    apply_stimulus(1'b0, 16'd1, 1);
    underrun_clr = 1'b0;
    check_output("clr_underrun", 32'(underrun), 32'd0);

    $display("[TB] disable in a tick cycle");
    clear_logs();
    push(32'hC1); push(32'hC2); push(32'hC3);
    apply_stimulus(1'b1, 16'd3, 1);
    begin
      int n;
      n = 0;
      while (n < 20 && !fifo_read_en) begin @(negedge clk); n++; end
      check_output("dis_first_pop_seen", 32'(fifo_read_en), 32'd1);
    end
    repeat (4) begin @(posedge clk); #2; end
    enable = 1'b0;
    rp = rd_ptr;
    @(negedge clk);
    check_output("dis_read_en", 32'(fifo_read_en), 32'd0);
    check_output("dis_fifo_nonempty", 32'(fifo_empty), 32'd0);
    apply_stimulus(1'b0, 16'd3, 3);
    check_output("dis_rd_ptr", rd_ptr, rp);
    check_output("dis_sample_held", sample_out, 32'hC1);
    check_output("dis_vld", 32'(sample_vld), 32'd0);

    $display("[TB] back-to-back, rate_div=0");
    fifo_flush = 1'b1;
    apply_stimulus(1'b0, 16'd0, 1);
    fifo_flush = 1'b0;
    clear_logs();
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    apply_stimulus(1'b1, 16'd0, 25);
    check_output("b2b_pops", pop_cyc.size(), 32'd16);
    if (pop_cyc.size() == 16 && vld_s.size() >= 18) begin
      check_output("b2b_span", pop_cyc[15] - pop_cyc[0], 32'd15);
      check_output("b2b_vld_span", vld_cyc[15] - vld_cyc[0], 32'd15);
      for (int i = 0; i < 16; i++) check_output("b2b_sample", vld_s[i], 32'h100 + i);
      check_output("b2b_hold", vld_s[16], 32'h10F);
      check_output("b2b_hold_ur", 32'(vld_u[16]), 32'd1);
      check_output("b2b_mute", vld_s[17], 32'h0);
    end else check_output("b2b_log_size", vld_s.size(), 32'd18);

    apply_stimulus(1'b0, 16'd0, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
